// File: rtl/avmm_ram_responder_if.sv
// ---------------------------------------------------------------------------
// avmm_ram_responder_if
//   Avalon-MM pipelined bus between a master and the on-chip RAM responder.
//   Signals:
//     address       master -> slave  32  byte address
//     read          master -> slave   1  read request
//     write         master -> slave   1  write request
//     writedata     master -> slave  32  write data
//     byteenable    master -> slave   4  write lane enables
//     readdata      slave -> master  32  read data (valid with readdatavalid)
//     waitrequest   slave -> master   1  command not accepted this cycle
//     readdatavalid slave -> master   1  one-cycle pulse per returned read
//     pending       slave -> master   4  reads currently outstanding
//     protocol_err  slave -> master   1  sticky: read and write seen together
// ---------------------------------------------------------------------------
interface avmm_ram_responder_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        readdatavalid;
    logic [3:0]  pending;
    logic        protocol_err;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, waitrequest, readdatavalid, pending, protocol_err
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, waitrequest, readdatavalid, pending, protocol_err
    );
endinterface

// File: rtl/avmm_ram_responder.sv
// ---------------------------------------------------------------------------
// avmm_ram_responder
//   Avalon-MM pipelined slave backed by a 32-bit on-chip RAM. Stands in for
//   the SDRAM controller so bus masters can be brought up without DRAM.
//   Fixed read latency, bounded outstanding reads, byte-lane writes.
//
// Parameters
//   ADDR_BITS     word-address bits; depth = 2**ADDR_BITS words
//   READ_LATENCY  cycles from read accept to readdatavalid (1..4)
//   MAX_PENDING   max accepted-but-unreturned reads (1..15)
//
// Ports
//   clk   in   system clock
//   rst   in   asynchronous reset, active-low
//   bus   slave modport of avmm_ram_responder_if
//
// Build option
//   AVMM_RAM_STALL_EN  when defined, an 8-bit LFSR throws pseudo-random
//                      waitrequest stalls on reads and writes to exercise
//                      master-side waitrequest handling.
// ---------------------------------------------------------------------------
module avmm_ram_responder #(
    parameter int ADDR_BITS    = 10,
    parameter int READ_LATENCY = 2,
    parameter int MAX_PENDING  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    avmm_ram_responder_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [31:0]          mem_q [DEPTH];
    logic [ADDR_BITS-1:0] word_idx;
    logic                 stall;
    logic                 wait_req;
    logic                 rd_accept;
    logic                 wr_accept;
    logic                 rdv;
    logic                 pending_full;

    // Stage k holds a read accepted k+1 edges ago; the last stage drives the bus.
    logic [READ_LATENCY-1:0] vld_q;
    logic [31:0]             data_q [READ_LATENCY];

    logic [3:0] pending_q, pending_d;
    logic       perr_q, perr_d;

    // Byte offset and bits above the RAM size are ignored, so aliases hit the same word.
    assign word_idx = bus.address[ADDR_BITS+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.address[31:ADDR_BITS+2], bus.address[1:0]};

`ifdef AVMM_RAM_STALL_EN
    // Fibonacci LFSR, taps 8,6,5,4; deterministic sequence from reset.
    logic [7:0] lfsr_q, lfsr_d;

    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign stall  = (lfsr_q[1:0] == 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= 8'hA5;
        else      lfsr_q <= lfsr_d;
    end
`else
    assign stall = 1'b0;
`endif

    assign rdv          = vld_q[READ_LATENCY-1];
    // A return in this cycle frees a slot, so a read may still be taken when full.
    assign pending_full = (pending_q == 4'(MAX_PENDING)) && !rdv;
    assign wait_req     = !rst || (bus.read && pending_full) || stall;

    // read together with write is executed as a write only.
    assign wr_accept = bus.write && !wait_req;
    assign rd_accept = bus.read && !bus.write && !wait_req;

    // NOTE: every variable gets its default before any branch so no latch is inferred.
    always_comb begin
        pending_d = pending_q;
        if (rd_accept && !rdv)      pending_d = pending_q + 4'd1;
        else if (!rd_accept && rdv) pending_d = pending_q - 4'd1;
        perr_d = perr_q || (bus.read && bus.write);
    end

    // NOTE: RAM contents are deliberately left out of reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.byteenable[i]) mem_q[word_idx][8*i +: 8] <= bus.writedata[8*i +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q     <= '0;
            pending_q <= '0;
            perr_q    <= 1'b0;
            for (int k = 0; k < READ_LATENCY; k++) data_q[k] <= '0;
        end else begin
            pending_q <= pending_d;
            perr_q    <= perr_d;
            // RAM is read at the accept edge, so a write accepted one edge earlier is visible.
            vld_q[0] <= rd_accept;
            if (rd_accept) data_q[0] <= mem_q[word_idx];
            // Data only moves with a valid read, so the last stage holds between returns.
            for (int k = 1; k < READ_LATENCY; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) data_q[k] <= data_q[k-1];
            end
        end
    end

    assign bus.waitrequest   = wait_req;
    assign bus.readdatavalid = rdv;
    assign bus.readdata      = data_q[READ_LATENCY-1];
    assign bus.pending       = pending_q;
    assign bus.protocol_err  = perr_q;
endmodule

// File: tb/tb_avmm_ram_responder.sv
// ---------------------------------------------------------------------------
// tb_avmm_ram_responder
//   Self-checking bench for avmm_ram_responder. Two instances: u_dut with
//   default parameters and u_dut3 with READ_LATENCY=3, MAX_PENDING=2.
//   Expected read data is taken from a bench-side memory model when a read is
//   accepted and pushed to a queue; monitors pop and compare on readdatavalid.
// ---------------------------------------------------------------------------
module tb_avmm_ram_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    avmm_ram_responder_if m ();
    avmm_ram_responder_if m3 ();

    avmm_ram_responder u_dut (
        .clk (clk),
        .rst (rst),
        .bus (m.slave)
    );

    avmm_ram_responder #(.ADDR_BITS(10), .READ_LATENCY(3), .MAX_PENDING(2)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (m3.slave)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] model  [1024];
    logic [31:0] model3 [1024];
    logic [31:0] exp_q  [$];
    logic [31:0] exp3_q [$];
    logic        saw_wait = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, expv);
        end
    endtask

    function automatic logic busy(input bit sel);
        return sel ? m3.waitrequest : m.waitrequest;
    endfunction

    // Drives one command at a negedge, holds it until accepted, returns at the accept edge.
    task automatic issue(input bit sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        int n;
        logic [9:0] idx;
        @(negedge clk);
        if (sel) begin
            m3.read = rd; m3.write = wr; m3.address = a; m3.writedata = d; m3.byteenable = be;
        end else begin
            m.read = rd; m.write = wr; m.address = a; m.writedata = d; m.byteenable = be;
        end
        #1;
        n = 0;
        while (busy(sel) === 1'b1 && n < 64) begin
            if (!sel) saw_wait = 1'b1;
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 64) check("accept_timeout", 32'(n), 32'd0);
        idx = a[11:2];
        if (wr) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    if (sel) model3[idx][8*i +: 8] = d[8*i +: 8];
                    else     model[idx][8*i +: 8]  = d[8*i +: 8];
                end
            end
        end else if (rd) begin
            if (sel) exp3_q.push_back(model3[idx]);
            else     exp_q.push_back(model[idx]);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        m.read = 1'b0;  m.write = 1'b0;
        m3.read = 1'b0; m3.write = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp3_q.size() != 0 || m.pending != 0 || m3.pending != 0)
               && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("drain_queues", 32'(exp_q.size() + exp3_q.size()), 32'd0);
    endtask

    // Scoreboard monitors: every readdatavalid must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && m.readdatavalid === 1'b1) begin
            if (exp_q.size() == 0) check("rdv_unexpected", 32'd1, 32'd0);
            else                   check("rdata", m.readdata, exp_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst && m3.readdatavalid === 1'b1) begin
            if (exp3_q.size() == 0) check("rdv3_unexpected", 32'd1, 32'd0);
            else                    check("rdata3", m3.readdata, exp3_q.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] t3_addr [4];
    int          k;
    int          cyc;
    int          n_ops;

    initial begin
        m.read = 0;  m.write = 0;  m.address = 0;  m.writedata = 0;  m.byteenable = 0;
        m3.read = 0; m3.write = 0; m3.address = 0; m3.writedata = 0; m3.byteenable = 0;

        // Reset state
        #1;
        check("rst_waitrequest", 32'(m.waitrequest), 32'd1);
        check("rst_rdv", 32'(m.readdatavalid), 32'd0);
        check("rst_pending", 32'(m.pending), 32'd0);
        check("rst_perr", 32'(m.protocol_err), 32'd0);
        check("rst_readdata", m.readdata, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
`ifndef AVMM_RAM_STALL_EN
        check("idle_waitrequest", 32'(m.waitrequest), 32'd0);
`endif

        // T1: full-word write, read back with latency 2, pending 1 -> 0
        issue(0, 0, 1, 32'h0000_0010, 32'hDEADBEEF, 4'hF);
        issue(0, 1, 0, 32'h0000_0010, 32'h0, 4'h0);
        idle();
        check("t1_rdv_c1", 32'(m.readdatavalid), 32'd0);
        check("t1_pend_c1", 32'(m.pending), 32'd1);
        @(negedge clk);
        check("t1_rdv_c2", 32'(m.readdatavalid), 32'd1);
        check("t1_data_c2", m.readdata, 32'hDEADBEEF);
        @(negedge clk);
        check("t1_rdv_c3", 32'(m.readdatavalid), 32'd0);
        check("t1_pend_c3", 32'(m.pending), 32'd0);
        check("t1_hold", m.readdata, 32'hDEADBEEF);

        // T2: partial lanes, then a read the very next cycle
        issue(0, 0, 1, 32'h0000_0010, 32'h11223344, 4'b0101);
        issue(0, 1, 0, 32'h0000_0010, 32'h0, 4'h0);
        idle();
        drain();
        check("t2_data", m.readdata, 32'hDE22BE44);

        // T4: address aliasing, and byteenable=0 leaves the word unchanged
        issue(0, 0, 1, 32'h0000_1004, 32'hCAFEF00D, 4'hF);
        issue(0, 1, 0, 32'h0000_0004, 32'h0, 4'h0);
        issue(0, 1, 0, 32'h0000_0007, 32'h0, 4'h0);
        issue(0, 0, 1, 32'hFFFF_F004, 32'hFFFFFFFF, 4'h0);
        issue(0, 1, 0, 32'h0000_1006, 32'h0, 4'h0);
        idle();
        drain();
        check("t4_data", m.readdata, 32'hCAFEF00D);

        // T3: READ_LATENCY=3, MAX_PENDING=2, read held high with 4 addresses
        t3_addr[0] = 32'h0000_0100; t3_addr[1] = 32'h0000_0204;
        t3_addr[2] = 32'h0000_0308; t3_addr[3] = 32'h0000_040C;
        for (int i = 0; i < 4; i++) issue(1, 0, 1, t3_addr[i], 32'hA000_0000 + 32'(i * 17), 4'hF);
        idle();
        k = 0;
        cyc = 0;
        while (k < 4 && cyc < 40) begin
            if (cyc != 0) @(negedge clk);
            m3.read = 1'b1; m3.write = 1'b0; m3.address = t3_addr[k];
            #1;
`ifndef AVMM_RAM_STALL_EN
            check($sformatf("t3_wait_c%0d", cyc), 32'(m3.waitrequest), (cyc == 2) ? 32'd1 : 32'd0);
`endif
            if (!m3.waitrequest) begin
                exp3_q.push_back(model3[t3_addr[k][11:2]]);
                k++;
            end
            @(posedge clk);
            cyc++;
        end
        check("t3_accepts", 32'(k), 32'd4);
`ifndef AVMM_RAM_STALL_EN
        check("t3_cycles", 32'(cyc), 32'd5);
`endif
        idle();
        drain();
        check("t3_last", m3.readdata, 32'hA000_0033);

        // T5: reset with reads in flight discards them
        issue(0, 1, 0, 32'h0000_0010, 32'h0, 4'h0);
        issue(0, 1, 0, 32'h0000_1004, 32'h0, 4'h0);
        #1;
        rst = 1'b0;
        m.read = 1'b0;
        exp_q.delete();
        #1;
        check("t5_wait_in_rst", 32'(m.waitrequest), 32'd1);
        check("t5_pend_in_rst", 32'(m.pending), 32'd0);
        check("t5_rdv_in_rst", 32'(m.readdatavalid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_no_rdv", 32'(m.readdatavalid), 32'd0);
        end
        check("t5_pend_after", 32'(m.pending), 32'd0);
        issue(0, 1, 0, 32'h0000_0010, 32'h0, 4'h0);
        issue(0, 1, 0, 32'h0000_1004, 32'h0, 4'h0);
        idle();
        drain();

        // T6: read and write together -> write only, sticky protocol_err
        check("t6_perr_before", 32'(m.protocol_err), 32'd0);
        issue(0, 1, 1, 32'h0000_0020, 32'h5A5A5A5A, 4'hF);
        idle();
        check("t6_perr_set", 32'(m.protocol_err), 32'd1);
        repeat (3) @(negedge clk);
        check("t6_pend", 32'(m.pending), 32'd0);
        issue(0, 1, 0, 32'h0000_0020, 32'h0, 4'h0);
        idle();
        drain();
        check("t6_data", m.readdata, 32'h5A5A5A5A);
        check("t6_perr_sticky", 32'(m.protocol_err), 32'd1);

        // Random traffic against the model over 16 words with aliased addresses
        for (int i = 0; i < 16; i++)
            issue(0, 0, 1, {$urandom_range(0, 255) << 12} | 32'(i << 2), $urandom, 4'hF);
`ifdef AVMM_RAM_STALL_EN
        n_ops = 1000;
`else
        n_ops = 300;
`endif
        for (int i = 0; i < n_ops; i++) begin
            int          r;
            logic [31:0] a;
            r = $urandom_range(0, 99);
            a = (32'($urandom) & 32'hFFFF_F003) | 32'($urandom_range(0, 15) << 2);
            if (r < 45)      issue(0, 1, 0, a, $urandom, 4'($urandom));
            else if (r < 92) issue(0, 0, 1, a, $urandom, 4'($urandom));
            else             issue(0, 1, 1, a, $urandom, 4'($urandom));
            if (r % 7 == 0) idle();
        end
        idle();
        drain();
`ifdef AVMM_RAM_STALL_EN
        check("stall_seen", 32'(saw_wait), 32'd1);
`else
        check("no_spurious_wait", 32'(saw_wait), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
